// File: rtl/ppcm_wb_line_reader.sv
// Read-only Wishbone slave that serves CPU word reads from a one-line (4 x 32-bit)
// buffer and refills that buffer with 4-word bursts from the parallel PCM core.
module ppcm_wb_line_reader #(
   parameter int ADDR_BITS = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   input  logic [ADDR_BITS-3:0] wb_addr_i,
   output logic [31:0]          wb_data_o,
   output logic                 wb_ack_o,
   output logic                 wb_err_o,
   input  logic                 flush,
   output logic                 core_cs,
   output logic                 core_burst,
   output logic [ADDR_BITS-3:0] core_addr,
   input  logic [31:0]          core_dout,
   input  logic                 core_busy,
   input  logic                 core_ack
);

   localparam int TW = ADDR_BITS - 4;

   // state  | meaning
   // S_IDLE | serve hits / reject writes / start a refill on a miss
   // S_FILL | burst in progress, capturing one word per core_ack
   // S_RESP | line complete, answer the pending read if still requested
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP} state_t;

   state_t          state_q, state_d;
   logic            line_valid_q, line_valid_d;
   logic [TW-1:0]   tag_q, tag_d;
   logic [TW-1:0]   ftag_q, ftag_d;
   logic [1:0]      fword_q, fword_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            flushed_q, flushed_d;
   logic [3:0][31:0] line_q, line_d;
   logic [31:0]     data_q, data_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic            cs_q, cs_d;

   logic            req;
   logic            hit;

   assign req = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
   // A flush in the same cycle as a lookup forces a miss.
   assign hit = line_valid_q & (tag_q == wb_addr_i[ADDR_BITS-3:2]) & ~flush;

   always_comb begin
      state_d      = state_q;
      line_valid_d = line_valid_q;
      tag_d        = tag_q;
      ftag_d       = ftag_q;
      fword_d      = fword_q;
      cnt_d        = cnt_q;
      flushed_d    = flushed_q;
      line_d       = line_q;
      data_d       = data_q;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      cs_d         = cs_q;

      unique case (state_q)
         S_IDLE: begin
            if (flush) line_valid_d = 1'b0;
            if (req) begin
               if (wb_we_i) begin
                  err_d = 1'b1;
               end else if (hit) begin
                  ack_d  = 1'b1;
                  data_d = line_q[wb_addr_i[1:0]];
               end else if (!core_busy) begin
                  ftag_d       = wb_addr_i[ADDR_BITS-3:2];
                  fword_d      = wb_addr_i[1:0];
                  cnt_d        = 2'd0;
                  flushed_d    = 1'b0;
                  line_valid_d = 1'b0;
                  cs_d         = 1'b1;
                  state_d      = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (flush) flushed_d = 1'b1;
            if (core_ack) begin
               line_d[cnt_q] = core_dout;
               cnt_d         = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  cs_d         = 1'b0;
                  tag_d        = ftag_q;
                  line_valid_d = ~(flushed_q | flush);
                  state_d      = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (flush) line_valid_d = 1'b0;
            if (wb_cyc_i && wb_stb_i) begin
               ack_d  = 1'b1;
               data_d = line_q[fword_q];
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         line_valid_q <= 1'b0;
         tag_q        <= '0;
         ftag_q       <= '0;
         fword_q      <= 2'd0;
         cnt_q        <= 2'd0;
         flushed_q    <= 1'b0;
         line_q       <= '0;
         data_q       <= '0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         cs_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_valid_q <= line_valid_d;
         tag_q        <= tag_d;
         ftag_q       <= ftag_d;
         fword_q      <= fword_d;
         cnt_q        <= cnt_d;
         flushed_q    <= flushed_d;
         line_q       <= line_d;
         data_q       <= data_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         cs_q         <= cs_d;
      end
   end

   assign wb_data_o  = data_q;
   assign wb_ack_o   = ack_q;
   assign wb_err_o   = err_q;
   assign core_cs    = cs_q;
   assign core_burst = cs_q;
   assign core_addr  = {ftag_q, 2'b00};

endmodule

// File: tb/tb_ppcm_wb_line_reader.sv
// Scoreboarded bench for ppcm_wb_line_reader: a line-cache reference model predicts
// each response and refill, a behavioural PCM core answers bursts.
module tb_ppcm_wb_line_reader;

   localparam int AB = 24;
   localparam int AW = AB - 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [AW-1:0] wb_addr_i = '0;
   logic [31:0]   wb_data_o;
   logic          wb_ack_o, wb_err_o;
   logic          flush = 1'b0;
   logic          core_cs, core_burst;
   logic [AW-1:0] core_addr;
   logic [31:0]   core_dout;
   logic          core_busy = 1'b0;
   logic          core_ack;

   ppcm_wb_line_reader #(.ADDR_BITS(AB)) dut (
      .clk(clk), .rst(rst),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_addr_i(wb_addr_i), .wb_data_o(wb_data_o),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .flush(flush),
      .core_cs(core_cs), .core_burst(core_burst), .core_addr(core_addr),
      .core_dout(core_dout), .core_busy(core_busy), .core_ack(core_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0;
   int            failures = 0;
   int            fill_cnt = 0;
   logic [AW-1:0] exp_line = '0;

   // reference model: one buffered line
   logic          m_valid = 1'b0;
   logic [AW-3:0] m_tag = '0;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return ({10'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (!rst && (wb_ack_o || wb_err_o)) begin
         exp_t e;
         chk("ack_err_exclusive", {31'd0, wb_ack_o & wb_err_o}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_response actual=ack%0b/err%0b required=none", wb_ack_o, wb_err_o);
         end else begin
            e = exp_q.pop_front();
            chk("resp_is_err", {31'd0, wb_err_o}, {31'd0, e.err});
            if (!e.err) chk("rd_data", wb_data_o, e.data);
         end
      end
   end

   // behavioural PCM core
   initial begin
      logic [AW-1:0] base;
      core_ack  = 1'b0;
      core_dout = '0;
      forever begin
         @(negedge clk);
         if (core_cs && !rst) begin
            fill_cnt++;
            chk("core_addr", {10'd0, core_addr}, {10'd0, exp_line});
            chk("core_burst", {31'd0, core_burst}, 32'd1);
            base = core_addr;
            for (int w = 0; w < 4; w++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               if (!core_cs || rst) break;
               core_dout = mem_word(base + AW'(w));
               core_ack  = 1'b1;
               @(negedge clk);
               core_ack  = 1'b0;
            end
         end
      end
   end

   // One bus transfer; caller is positioned at a negedge.
   task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic flush_issue,
                         input logic flush_mid, input int busy_cycles);
      exp_t e;
      int   exp_fill;
      int   fills0;
      bit   done;
      logic fm;
      if (flush_issue) m_valid = 1'b0;
      fm = 1'b0;
      exp_fill = 0;
      e.err = we;
      e.data = '0;
      if (!we) begin
         e.data = mem_word(addr);
         if (!(m_valid && m_tag == addr[AW-1:2])) begin
            exp_fill = 1;
            fm       = flush_mid && busy_cycles == 0;
            m_tag    = addr[AW-1:2];
            m_valid  = !fm;
         end
      end
      exp_line = {addr[AW-1:2], 2'b00};
      exp_q.push_back(e);
      fills0    = fill_cnt;
      core_busy = busy_cycles > 0;
      wb_cyc_i  = 1'b1;
      wb_stb_i  = 1'b1;
      wb_we_i   = we;
      wb_addr_i = addr;
      flush     = flush_issue;
      done      = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         flush = 1'b0;
         if (i < busy_cycles) chk("cs_held_while_busy", {31'd0, core_cs}, 32'd0);
         if (i == busy_cycles - 1) core_busy = 1'b0;
         if (fm && i == 0) flush = 1'b1;
         if (wb_ack_o || wb_err_o) done = 1'b1;
      end
      core_busy = 1'b0;
      wb_cyc_i  = 1'b0;
      wb_stb_i  = 1'b0;
      wb_we_i   = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL response_timeout actual=none required=response addr=%h", addr);
         exp_q.delete();
      end
      @(negedge clk);
      chk("fill_count", fill_cnt - fills0, exp_fill);
   endtask

   task automatic reset_mid_fill(input logic [AW-1:0] addr);
      bit seen = 1'b0;
      m_valid   = 1'b0;
      exp_line  = {addr[AW-1:2], 2'b00};
      wb_cyc_i  = 1'b1;
      wb_stb_i  = 1'b1;
      wb_we_i   = 1'b0;
      wb_addr_i = addr;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (core_cs) seen = 1'b1;
      end
      chk("rst_fill_started", {31'd0, seen}, 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_core_cs", {31'd0, core_cs}, 32'd0);
      chk("rst_core_burst", {31'd0, core_burst}, 32'd0);
      chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
      chk("rst_data", wb_data_o, 32'd0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_ack", {31'd0, wb_ack_o}, 32'd0);
      chk("reset_err", {31'd0, wb_err_o}, 32'd0);
      chk("reset_data", wb_data_o, 32'd0);
      chk("reset_cs", {31'd0, core_cs}, 32'd0);
      chk("reset_burst", {31'd0, core_burst}, 32'd0);
      chk("reset_core_addr", {10'd0, core_addr}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_req(1'b0, 22'h4, 1'b0, 1'b0, 0);   // cold read 0x10
      do_req(1'b0, 22'h7, 1'b0, 1'b0, 0);   // hit 0x1C
      do_req(1'b0, 22'h8, 1'b0, 1'b0, 0);   // new line 0x20
      do_req(1'b0, 22'h4, 1'b0, 1'b0, 0);   // old line was replaced
      do_req(1'b1, 22'h5, 1'b0, 1'b0, 0);   // write rejected
      do_req(1'b0, 22'h6, 1'b0, 1'b0, 0);   // buffer untouched by the write
      do_req(1'b0, 22'h20, 1'b0, 1'b1, 0);  // flush during fill
      do_req(1'b0, 22'h20, 1'b0, 1'b0, 0);  // refill after flush
      do_req(1'b0, 22'h21, 1'b1, 1'b0, 0);  // flush with hit -> miss
      do_req(1'b0, 22'h40, 1'b0, 1'b0, 5);  // core busy during init
      reset_mid_fill(22'h80);
      do_req(1'b0, 22'h81, 1'b0, 1'b0, 0);  // cold again after reset

      for (int n = 0; n < 200; n++) begin
         logic [AW-1:0] a;
         int            r;
         a = {20'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 15) == 0) a[AW-1:2] = 20'hFFFFF;
         r = $urandom_range(0, 11);
         if ($urandom_range(0, 9) == 0) begin
            flush = 1'b1;
            m_valid = 1'b0;
            @(negedge clk);
            flush = 1'b0;
         end
         do_req($urandom_range(0, 7) == 0, a, $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0, (r == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
